// File: rtl/fifo_rr_drain_scheduler_if.sv
// Handshake bundle between the drain scheduler, its upstream FIFOs and the
// downstream consumer. "master" is the scheduler side, "slave" the environment.
interface fifo_rr_drain_scheduler_if #(
    parameter int n_ch  = 4,
    parameter int width = 8
);
    localparam int ch_w = $clog2(n_ch);

    logic [n_ch-1:0]       fifo_empty;
    logic [n_ch*width-1:0] fifo_read_data;
    logic [n_ch-1:0]       fifo_pop;
    logic                  out_valid;
    logic                  out_ready;
    logic [width-1:0]      out_data;
    logic [ch_w-1:0]       out_ch;
    logic                  busy;

    modport master (
        input  fifo_empty, fifo_read_data, out_ready,
        output fifo_pop, out_valid, out_data, out_ch, busy
    );

    modport slave (
        output fifo_empty, fifo_read_data, out_ready,
        input  fifo_pop, out_valid, out_data, out_ch, busy
    );
endinterface

// File: rtl/fifo_rr_drain_scheduler.sv
// Round-robin drain scheduler: grants one upstream FIFO at a time, forwards up
// to max_burst words from it, then moves priority to the next channel.
module fifo_rr_drain_scheduler #(
    parameter int n_ch      = 4,
    parameter int width     = 8,
    parameter int max_burst = 4
) (
    input  logic clk,
    input  logic rst,
    fifo_rr_drain_scheduler_if.master bus
);
    localparam int ch_w = $clog2(n_ch);
    localparam int bc_w = $clog2(max_burst + 1);

    typedef enum logic {
        ARB   = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [ch_w-1:0] grant_q, grant_d;
    logic [ch_w-1:0] rr_ptr_q, rr_ptr_d;
    logic [bc_w-1:0] burst_cnt_q, burst_cnt_d;

    logic            found_s;
    logic [ch_w-1:0] found_idx_s;
    logic [ch_w-1:0] grant_inc_s;
    logic            grant_empty_s;
    logic            xfer_s;

    // Scan for the first non-empty channel starting at rr_ptr, wrapping.
    always_comb begin
        found_s     = 1'b0;
        found_idx_s = '0;
        for (int k = 0; k < n_ch; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % n_ch;
            if (!found_s && !bus.fifo_empty[idx]) begin
                found_s     = 1'b1;
                found_idx_s = ch_w'(idx);
            end else begin
                found_s     = found_s;
            end
        end
    end

    // Channel following the current grant, wrapping at n_ch-1 (also covers non-power-of-two n_ch).
    always_comb begin
        if (grant_q == ch_w'(n_ch - 1)) begin
            grant_inc_s = '0;
        end else begin
            grant_inc_s = grant_q + ch_w'(1);
        end
    end

    assign grant_empty_s = bus.fifo_empty[grant_q];
    assign xfer_s        = (state_q == SERVE) && !grant_empty_s && bus.out_ready;

    // Next-state logic and handshake outputs; outputs are quiet in ARB.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_ptr_d       = rr_ptr_q;
        burst_cnt_d    = burst_cnt_q;
        bus.out_valid  = 1'b0;
        bus.fifo_pop   = '0;
        bus.out_data   = bus.fifo_read_data[int'(grant_q)*width +: width];
        bus.out_ch     = grant_q;
        bus.busy       = (state_q == SERVE);
        case (state_q)
            ARB: begin
                if (found_s) begin
                    state_d     = SERVE;
                    grant_d     = found_idx_s;
                    burst_cnt_d = '0;
                end else begin
                    state_d     = ARB;
                end
            end
            SERVE: begin
                bus.out_valid = !grant_empty_s;
                if (xfer_s) begin
                    bus.fifo_pop[grant_q] = 1'b1;
                    burst_cnt_d           = burst_cnt_q + bc_w'(1);
                end else begin
                    burst_cnt_d           = burst_cnt_q;
                end
                // Burst limit wins over a just-emptied FIFO; both release identically.
                if (xfer_s && (burst_cnt_q == bc_w'(max_burst - 1))) begin
                    state_d  = ARB;
                    rr_ptr_d = grant_inc_s;
                end else if (grant_empty_s) begin
                    state_d  = ARB;
                    rr_ptr_d = grant_inc_s;
                end else begin
                    state_d  = SERVE;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    // State register; reset aborts any burst and restarts priority at channel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
endmodule

// File: doc/fifo_rr_drain_scheduler.md
FIFO_RR_DRAIN_SCHEDULER -- requirements
Module: fifo_rr_drain_scheduler

Interface
REQ-001 Parameter n_ch, default 4: number of upstream FIFOs served; legal range is 2 or more.
REQ-002 Parameter width, default 8: data word width.
REQ-003 Parameter max_burst, default 4: maximum words per grant; legal range is 1 or more.
REQ-004 clk  input  1  clock; all state updates on posedge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 fifo_empty  input  n_ch  per-channel empty flag from the upstream FIFOs.
REQ-007 fifo_read_data  input  n_ch*width  per-channel head word (fall-through); channel i occupies bits [i*width +: width].
REQ-008 fifo_pop  output  n_ch  per-channel pop strobe; at most one bit high per cycle.
REQ-009 out_valid  output  1  out_data is valid.
REQ-010 out_ready  input  1  consumer accepts the word.
REQ-011 out_data  output  width  word forwarded from the granted channel.
REQ-012 out_ch  output  $clog2(n_ch)  index of the granted channel.
REQ-013 busy  output  1  the block is in state SERVE.

Function
REQ-014 The FSM SHALL have exactly two states: ARB and SERVE.
REQ-015 Registers: state, grant (the current channel index), rr_ptr (the next-priority channel index), burst_cnt ($clog2(max_burst+1) bits).
REQ-016 ARB: the block SHALL search for the first channel i with fifo_empty[i]=0, scanning upward from rr_ptr and wrapping modulo n_ch.
REQ-017 If ARB finds such a channel, then on the next posedge: grant <= i, burst_cnt <= 0, state <= SERVE.
REQ-018 If ARB finds no such channel, the FSM SHALL stay in ARB and leave rr_ptr unchanged.
REQ-019 In ARB, out_valid=0 and fifo_pop=0; this gives a fixed one-cycle arbitration latency.
REQ-020 SERVE outputs are combinational: out_valid = ~fifo_empty[grant]; out_data = fifo_read_data[grant]; out_ch = grant.
REQ-021 A transfer occurs when out_valid and out_ready are both 1 in SERVE; in that cycle fifo_pop[grant]=1 and every other pop bit is 0.
REQ-022 No pop SHALL be issued without out_ready=1; out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 On each transfer, burst_cnt SHALL increment by 1.
REQ-024 Release on burst limit: if a transfer occurs with burst_cnt = max_burst-1, then next state <= ARB and rr_ptr <= grant+1 (wrapping from n_ch-1 to 0).
REQ-025 Release on empty: if in SERVE with fifo_empty[grant]=1, then next state <= ARB and rr_ptr <= grant+1 (wrapping).
REQ-026 When the last word of a channel is popped, its empty flag is seen one cycle later; that produces one idle SERVE cycle and then ARB (no extra pop).
REQ-027 Otherwise SERVE SHALL hold grant, rr_ptr and state.
REQ-028 Simultaneous events: when the burst limit and a just-emptied FIFO coincide, the burst-limit release SHALL apply (identical effect).
REQ-029 Fairness: with all channels permanently non-empty and out_ready=1, grants SHALL rotate 0,1,...,n_ch-1,0 with exactly max_burst transfers each.
REQ-030 busy = (state == SERVE).

Reset
REQ-031 While rst=1: state=ARB, grant=0, rr_ptr=0, burst_cnt=0; outputs out_valid=0, fifo_pop=0, busy=0, out_ch=0.
REQ-032 Reset asserted mid-burst SHALL abort the burst immediately, with no pop in that cycle.
REQ-033 After reset release, arbitration SHALL restart from channel 0.

Verification
REQ-034 Single channel: ch2 holds 3 words {A1,A2,A3}, others empty, out_ready=1 -> cycle 1 in ARB; cycles 2-4 transfer A1,A2,A3 with out_ch=2; cycle 5 idle SERVE; cycle 6 ARB with rr_ptr=3.
REQ-035 Burst limit: all channels hold 10 words, max_burst=4, out_ready=1 -> 4 pops of ch0, 1 ARB cycle, 4 pops of ch1, and so on; after ch3 the grant wraps to ch0.
REQ-036 Backpressure: in SERVE on ch1, out_ready=0 for 5 cycles -> out_valid=1 with constant out_data, fifo_pop=0, burst_cnt unchanged; the transfer completes on the first out_ready=1.
REQ-037 Skip-empty wrap: rr_ptr=3, only ch1 non-empty -> grant=1 after one ARB cycle; after release, rr_ptr=2.
REQ-038 Reset mid-burst: rst pulsed after 2 of 4 transfers on ch3 -> next cycle state=ARB, rr_ptr=0, no pop during reset, and the remaining words stay in ch3.
REQ-039 Continuous check: at most one fifo_pop bit is ever high, and no fifo_pop is issued to an empty channel.
